cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the 4-bit-PC core.
- Owns the program counter and the instruction register.
- Fetches 32-bit instructions over a request/acknowledge instruction-memory port and presents the latched instruction to the combinational decoder.
- Turns the decoder's level outputs into single-cycle commit strobes, sequences data-memory accesses, and applies jumps.
- Sits between instruction memory, the decoder, the register file and data memory; it is the only block that advances architectural state.

---
 rtl/cpu_ctrl_pkg.sv | 25 ++
 rtl/cpu_sequencer.sv | 123 ++++++++++++
 tb/tb_cpu_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
// Default widths, opcode field placement and the FSM state encoding.
package cpu_ctrl_pkg;

    localparam int unsigned DEFAULT_PC_W  = 4;
    localparam int unsigned DEFAULT_OP_W  = 32;
    localparam int unsigned DEFAULT_CNT_W = 16;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 28;
    localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_e;

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns pc and ir, handshakes instruction and data
// memory, and converts decoder levels into single-cycle commit strobes.
module cpu_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned PC_W  = DEFAULT_PC_W,
    parameter int unsigned OP_W  = DEFAULT_OP_W,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [OP_W-1:0]  imem_rdata,
    output logic [OP_W-1:0]  ir,
    input  logic             dec_pc_we,
    input  logic [PC_W-1:0]  dec_pc_in,
    input  logic             dec_reg_we,
    input  logic             dec_mem_we,
    output logic             reg_we,
    output logic             mem_req,
    input  logic             mem_ack,
    output logic [PC_W-1:0]  pc,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             halted,
    output logic [2:0]       state
);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [OP_W-1:0]  ir_q, ir_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic             imem_req_q, imem_req_d;
    logic             mem_req_q, mem_req_d;
    logic             reg_we_q, reg_we_d;
    logic             retire_q, retire_d;
    logic             halted_q, halted_d;
    logic             is_halt_c;

    assign is_halt_c = (ir_q[OPC_MSB:OPC_LSB] == OP_HALT);

    // Next-state and next-output logic; strobes are decoded from the next state
    // so they land in flops together with it and never see the ack inputs.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        retire_cnt_d = retire_cnt_q;

        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                if (is_halt_c)       state_d = HALT;
                else if (dec_mem_we) state_d = MEM;
                else                 state_d = WB;
            end
            MEM: begin
                if (mem_ack) state_d = WB;
            end
            WB: begin
                pc_d         = dec_pc_we ? dec_pc_in : pc_q + PC_W'(1);
                retire_cnt_d = retire_cnt_q + CNT_W'(1);
                state_d      = run ? FETCH : IDLE;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        imem_req_d = (state_d == FETCH);
        mem_req_d  = (state_d == MEM);
        retire_d   = (state_d == WB);
        reg_we_d   = (state_d == WB) && dec_reg_we;
        halted_d   = (state_d == HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            ir_q         <= '0;
            retire_cnt_q <= '0;
            imem_req_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            reg_we_q     <= 1'b0;
            retire_q     <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            retire_cnt_q <= retire_cnt_d;
            imem_req_q   <= imem_req_d;
            mem_req_q    <= mem_req_d;
            reg_we_q     <= reg_we_d;
            retire_q     <= retire_d;
            halted_q     <= halted_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign ir         = ir_q;
    assign reg_we     = reg_we_q;
    assign mem_req    = mem_req_q;
    assign pc         = pc_q;
    assign retire     = retire_q;
    assign retire_cnt = retire_cnt_q;
    assign halted     = halted_q;
    assign state      = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: plays instruction/data memory and the decoder, and
// checks every retire against an instruction-level model of the program.
module tb_cpu_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int unsigned PC_W  = 4;
    localparam int unsigned OP_W  = 32;
    localparam int unsigned CNT_W = 16;

    logic             clk, rst, run;
    logic             imem_req, imem_ack;
    logic [PC_W-1:0]  imem_addr;
    logic [OP_W-1:0]  imem_rdata, ir;
    logic             dec_pc_we, dec_reg_we, dec_mem_we;
    logic [PC_W-1:0]  dec_pc_in;
    logic             reg_we, mem_req, mem_ack, retire, halted;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] retire_cnt;
    logic [2:0]       state;

    cpu_sequencer #(.PC_W(PC_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .dec_pc_we(dec_pc_we), .dec_pc_in(dec_pc_in), .dec_reg_we(dec_reg_we),
        .dec_mem_we(dec_mem_we), .reg_we(reg_we), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc(pc), .retire(retire), .retire_cnt(retire_cnt), .halted(halted), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bench decoder: 0/1 write a register, 2 jumps to ir[3:0] (bit 27 also writes), 3 stores.
    logic [3:0] opc;
    assign opc        = ir[31:28];
    assign dec_reg_we = (opc == 4'h0) || (opc == 4'h1) || ((opc == 4'h2) && ir[27]);
    assign dec_pc_we  = (opc == 4'h2);
    assign dec_pc_in  = ir[PC_W-1:0];
    assign dec_mem_we = (opc == 4'h3);

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Program memory and per-address ack delays (negative means random 0..3).
    logic [31:0] prog [16];
    int          idelay_tab [16];
    int          mdelay_tab [16];
    bit          stray_en;

    // Instruction-level model state.
    logic [3:0]  m_pc;
    int unsigned m_cnt;

    int          cyc, fetch_cyc, last_fd, last_md, icnt, mcnt, lat;
    bit          ibusy, mbusy;
    logic [3:0]  faddr;
    logic [31:0] w;

    function automatic bit m_reg(input logic [31:0] x);
        logic [3:0] o;
        o = x[31:28];
        return (o <= 4'h1) || ((o == 4'h2) && x[27]);
    endfunction

    function automatic int pick(input int d);
        return (d < 0) ? int'($urandom_range(0, 3)) : d;
    endfunction

    // Monitor plus memory responders, all at the falling edge.
    initial begin
        imem_ack = 1'b0; imem_rdata = '0; mem_ack = 1'b0;
        cyc = 0; fetch_cyc = 0; last_fd = 0; last_md = 0; ibusy = 0; mbusy = 0;
        icnt = 0; mcnt = 0; faddr = '0;
        forever begin
            @(negedge clk);
            cyc++;
            imem_ack = 1'b0;
            mem_ack  = 1'b0;
            if (rst) begin
                ibusy = 0;
                mbusy = 0;
            end else begin
                check_eq("reg_we_without_retire", 32'(reg_we & ~retire), 32'd0);
                if (retire) begin
                    w   = prog[m_pc];
                    lat = last_fd + 3 + ((w[31:28] == 4'h3) ? last_md + 1 : 0);
                    check_eq("retire_pc", 32'(pc), 32'(m_pc));
                    check_eq("retire_ir", ir, w);
                    check_eq("retire_reg_we", 32'(reg_we), 32'(m_reg(w)));
                    check_eq("retire_cnt_in_wb", 32'(retire_cnt), 32'(CNT_W'(m_cnt)));
                    check_eq("retire_latency", 32'(cyc - fetch_cyc), 32'(lat));
                    m_pc = (w[31:28] == 4'h2) ? w[3:0] : m_pc + 4'd1;
                    m_cnt++;
                end
                if (mem_req) check_eq("mem_req_on_store", 32'(prog[m_pc][31:28]), 32'h3);

                if (imem_req) begin
                    if (!ibusy) begin
                        ibusy     = 1;
                        icnt      = pick(idelay_tab[imem_addr]);
                        last_fd   = icnt;
                        fetch_cyc = cyc;
                        faddr     = imem_addr;
                        check_eq("fetch_addr", 32'(imem_addr), 32'(m_pc));
                    end else begin
                        check_eq("fetch_addr_hold", 32'(imem_addr), 32'(faddr));
                    end
                    if (icnt == 0) begin
                        imem_ack   = 1'b1;
                        imem_rdata = prog[imem_addr];
                        ibusy      = 0;
                    end else begin
                        icnt--;
                    end
                end else begin
                    ibusy = 0;
                    if (stray_en && $urandom_range(0, 3) == 0) begin
                        imem_ack   = 1'b1;
                        imem_rdata = $urandom;
                    end
                end

                if (mem_req) begin
                    if (!mbusy) begin
                        mbusy   = 1;
                        mcnt    = pick(mdelay_tab[m_pc]);
                        last_md = mcnt;
                    end
                    if (mcnt == 0) begin
                        mem_ack = 1'b1;
                        mbusy   = 0;
                    end else begin
                        mcnt--;
                    end
                end else begin
                    mbusy = 0;
                    if (stray_en && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
                end
            end
        end
    end

    task automatic fill_nops();
        for (int i = 0; i < 16; i++) begin
            prog[i]       = 32'h4000_0000;
            idelay_tab[i] = 0;
            mdelay_tab[i] = 0;
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        run   = 1'b0;
        m_pc  = '0;
        m_cnt = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_state", 32'(state), 32'(IDLE));
        check_eq("rst_pc", 32'(pc), 32'd0);
        check_eq("rst_ir", ir, 32'd0);
        check_eq("rst_strobes", 32'({imem_req, reg_we, mem_req, retire, halted}), 32'd0);
        check_eq("rst_retire_cnt", 32'(retire_cnt), 32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_retired(input string tag, input int unsigned target, input int budget);
        int n;
        n = 0;
        while (retire_cnt != CNT_W'(target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(retire_cnt), target);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n;
        n = 0;
        while (state != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(state), 32'(st));
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; stray_en = 0; m_pc = '0; m_cnt = 0;
        fill_nops();

        // Register-write op, then a jump at pc 3, then a store with wait states at 9.
        prog[0] = 32'h0100_0000;
        prog[1] = 32'h1000_0000;
        prog[3] = 32'h2000_0009;
        prog[9] = 32'h3000_0000;
        idelay_tab[9] = 3;
        mdelay_tab[9] = 2;
        do_reset();
        run = 1'b1;
        wait_retired("first_retire", 1, 50);
        check_eq("pc_after_first", 32'(pc), 32'd1);
        wait_retired("jump_retire", 4, 50);
        check_eq("pc_after_jump", 32'(pc), 32'd9);
        wait_retired("store_retire", 5, 50);
        check_eq("pc_after_store", 32'(pc), 32'd10);

        // Random program with random ack delays, stray acks and run toggling.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            prog[i]        = $urandom;
            prog[i][31:28] = 4'($urandom_range(0, 14));
            idelay_tab[i]  = -1;
            mdelay_tab[i]  = -1;
        end
        stray_en = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            run = ($urandom_range(0, 7) != 0);
        end
        run = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("random_retire_total", 32'(retire_cnt), 32'(CNT_W'(m_cnt)));
        check_eq("random_final_pc", 32'(pc), 32'(m_pc));
        stray_en = 0;

        // Jump+write to 15, wrap to 0, then halt.
        do_reset();
        fill_nops();
        prog[0] = 32'h2800_000F;
        run = 1'b1;
        wait_retired("jump_to_15", 1, 50);
        prog[0] = 32'hF000_0000;
        wait_retired("wrap_retire", 2, 50);
        check_eq("pc_wrapped", 32'(pc), 32'd0);
        wait_state("enter_halt", HALT, 50);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            run = 1'($urandom);
            check_eq("halt_pc", 32'(pc), 32'd0);
            check_eq("halt_cnt", 32'(retire_cnt), 32'd2);
            check_eq("halt_flags", 32'({halted, imem_req, mem_req, retire}), 32'h8);
        end

        // Dropping run during DECODE still retires, then parks in IDLE.
        do_reset();
        fill_nops();
        run = 1'b1;
        wait_state("reach_decode", DECODE, 20);
        run = 1'b0;
        wait_retired("rundrop_retire", 1, 20);
        check_eq("rundrop_idle", 32'(state), 32'(IDLE));
        check_eq("rundrop_no_req", 32'(imem_req), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("rundrop_still_idle", 32'(state), 32'(IDLE));
        check_eq("rundrop_pc", 32'(pc), 32'd1);
        run = 1'b1;
        wait_retired("resume_retire", 2, 20);
        check_eq("resume_pc", 32'(pc), 32'd2);

        // Asynchronous reset while a store waits in MEM.
        do_reset();
        fill_nops();
        prog[1] = 32'h3000_0000;
        mdelay_tab[1] = 3;
        run = 1'b1;
        wait_state("reach_mem", MEM, 30);
        check_eq("mem_req_in_mem", 32'(mem_req), 32'd1);
        #1 rst = 1'b1;
        run = 1'b0;
        m_pc = '0;
        m_cnt = 0;
        #1;
        check_eq("async_mem_req", 32'(mem_req), 32'd0);
        check_eq("async_pc", 32'(pc), 32'd0);
        check_eq("async_state", 32'(state), 32'(IDLE));
        check_eq("async_cnt", 32'(retire_cnt), 32'd0);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("post_reset_cnt", 32'(retire_cnt), 32'd0);
        check_eq("post_reset_strobes", 32'({reg_we, retire, mem_req}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
